// File: rtl/hazard_ctrl_pkg.sv
// Shared stall codes and sequencer state encoding for the hazard controller.
package hazard_ctrl_pkg;

    localparam int STALL_WIDTH = 2;

    localparam logic [STALL_WIDTH-1:0] STALL_NONE   = 2'd0;
    localparam logic [STALL_WIDTH-1:0] STALL_LOAD   = 2'd1;
    localparam logic [STALL_WIDTH-1:0] STALL_BRANCH = 2'd2;
    localparam logic [STALL_WIDTH-1:0] STALL_MEM    = 2'd3;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_LOAD = 2'd1,
        S_MEM  = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_ctrl_detect.sv
// Load-use comparator: flags an ID operand that depends on a load still in EX.
module hazard_detect (
    input  logic       ex_is_load,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    output logic       hazard
);

    // x0 never carries a real result, so a load to it cannot create a dependency
    assign hazard = ex_is_load && (ex_rd != 5'd0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use bubbles, memory wait and branch flush with fixed priority.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT       = 255,
    parameter int CNT_WIDTH         = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             id_rs1,
    input  logic [4:0]             id_rs2,
    input  logic                   id_rs1_used,
    input  logic                   id_rs2_used,
    input  logic [4:0]             ex_rd,
    input  logic                   ex_is_load,
    input  logic                   branch_taken,
    input  logic                   dmem_req,
    input  logic                   dmem_ready,
    output logic [STALL_WIDTH-1:0] stall,
    output logic                   flush_if_id,
    output logic                   flush_id_ex,
    output logic                   mem_err,
    output logic [CNT_WIDTH-1:0]   perf_load_stalls,
    output logic [CNT_WIDTH-1:0]   perf_mem_stalls,
    output logic [CNT_WIDTH-1:0]   perf_flushes
);

    localparam int              TMO_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(MEM_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_MAX - 1'b1;
    localparam logic [2:0]      LOAD_INIT = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic            MULTI_LOAD = (LOAD_STALL_CYCLES > 1);

    state_t           state, next_state, ret_state, next_ret;
    logic [2:0]       load_cnt, next_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             hazard;
    logic             mem_wait;

    hazard_detect u_detect (
        .ex_is_load  (ex_is_load),
        .ex_rd       (ex_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .hazard      (hazard)
    );

    assign mem_wait = dmem_req && !dmem_ready;

    always_comb begin
        stall       = STALL_NONE;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        next_state  = state;
        next_ret    = ret_state;
        next_cnt    = load_cnt;
        unique case (state)
            S_RUN: begin
                if (mem_wait) begin
                    stall      = STALL_MEM;
                    next_ret   = S_RUN;
                    next_state = S_MEM;
                end else if (branch_taken) begin
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end else if (hazard) begin
                    stall       = STALL_LOAD;
                    flush_id_ex = 1'b1;
                    if (MULTI_LOAD) begin
                        next_cnt   = LOAD_INIT;
                        next_state = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (mem_wait) begin
                    stall      = STALL_MEM;
                    next_ret   = S_LOAD;
                    next_state = S_MEM;
                end else begin
                    stall       = STALL_LOAD;
                    flush_id_ex = 1'b1;
                    next_cnt    = load_cnt - 3'd1;
                    if (load_cnt == 3'd1) next_state = S_RUN;
                end
            end
            S_MEM: begin
                if (!dmem_ready) begin
                    stall = STALL_MEM;
                end else if (ret_state == S_LOAD) begin
                    // the ready cycle already counts as one of the owed load bubbles
                    stall       = STALL_LOAD;
                    flush_id_ex = 1'b1;
                    next_cnt    = load_cnt - 3'd1;
                    next_state  = (load_cnt == 3'd1) ? S_RUN : S_LOAD;
                end else begin
                    next_state = S_RUN;
                end
            end
            default: next_state = S_RUN;
        endcase
        if (rst) begin
            stall       = STALL_NONE;
            flush_if_id = 1'b0;
            flush_id_ex = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_RUN;
            ret_state <= S_RUN;
            load_cnt  <= 3'd0;
            tmo_cnt   <= '0;
            mem_err   <= 1'b0;
        end else begin
            state     <= next_state;
            ret_state <= next_ret;
            load_cnt  <= next_cnt;
            // only unanswered S_MEM cycles age the timeout; the FSM keeps waiting regardless
            if (state == S_MEM && !dmem_ready) begin
                if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + 1'b1;
                if (MEM_TIMEOUT != 0 && tmo_cnt == TMO_LAST) mem_err <= 1'b1;
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_WIDTH-1:0] load_q, mem_q, flush_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_q  <= '0;
            mem_q   <= '0;
            flush_q <= '0;
        end else begin
            if (stall == STALL_LOAD && load_q != '1) load_q  <= load_q + 1'b1;
            if (stall == STALL_MEM  && mem_q  != '1) mem_q   <= mem_q + 1'b1;
            if (flush_if_id && flush_q != '1)       flush_q <= flush_q + 1'b1;
        end
    end

    assign perf_load_stalls = load_q;
    assign perf_mem_stalls  = mem_q;
    assign perf_flushes     = flush_q;
`else
    assign perf_load_stalls = '0;
    assign perf_mem_stalls  = '0;
    assign perf_flushes     = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (1 and 3 load bubbles) against a bubble-count model.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_rs1_used, id_rs2_used, ex_is_load, branch_taken, dmem_req, dmem_ready;

    logic [1:0]  stall_o [2];
    logic        fif_o   [2];
    logic        fie_o   [2];
    logic        err_o   [2];
    logic [31:0] pl_o    [2];
    logic [31:0] pm_o    [2];
    logic [31:0] pf_o    [2];

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(TMO), .CNT_WIDTH(32)) dut_a (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
        .id_rs2_used(id_rs2_used), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .stall(stall_o[0]), .flush_if_id(fif_o[0]), .flush_id_ex(fie_o[0]), .mem_err(err_o[0]),
        .perf_load_stalls(pl_o[0]), .perf_mem_stalls(pm_o[0]), .perf_flushes(pf_o[0]));

    hazard_ctrl #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(TMO), .CNT_WIDTH(32)) dut_b (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
        .id_rs2_used(id_rs2_used), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .stall(stall_o[1]), .flush_if_id(fif_o[1]), .flush_id_ex(fie_o[1]), .mem_err(err_o[1]),
        .perf_load_stalls(pl_o[1]), .perf_mem_stalls(pm_o[1]), .perf_flushes(pf_o[1]));

    int pass_cnt = 0;
    int fail_cnt = 0;
    int tot_cnt  = 0;

    // model: bubbles still owed, waiting-on-memory flag, unanswered wait cycles, sticky error
    int          bubbles [2] = '{1, 3};
    int          owed [2], waiting [2], waited [2], err [2];
    int          n_owed [2], n_waiting [2], n_waited [2], n_err [2];
    int          e_stall [2], e_fif [2], e_fie [2];
    int unsigned c_load [2], c_mem [2], c_flush [2];

    task automatic chk(input string tag, input longint obs, input longint exp);
        tot_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit dep_on_load();
        return ex_is_load && ex_rd != 0 &&
               ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            owed[i] = 0; waiting[i] = 0; waited[i] = 0; err[i] = 0;
            c_load[i] = 0; c_mem[i] = 0; c_flush[i] = 0;
        end
    endtask

    task automatic model_eval();
        for (int i = 0; i < 2; i++) begin
            e_stall[i] = 0; e_fif[i] = 0; e_fie[i] = 0;
            n_owed[i] = owed[i]; n_waiting[i] = waiting[i]; n_waited[i] = waited[i]; n_err[i] = err[i];
            if (waiting[i] != 0) begin
                if (!dmem_ready) begin
                    e_stall[i] = 3;
                    n_waited[i] = waited[i] + 1;
                    if (n_waited[i] == TMO) n_err[i] = 1;
                end else begin
                    n_waiting[i] = 0; n_waited[i] = 0;
                    if (owed[i] > 0) begin
                        e_stall[i] = 1; e_fie[i] = 1; n_owed[i] = owed[i] - 1;
                    end
                end
            end else if (dmem_req && !dmem_ready) begin
                e_stall[i] = 3; n_waiting[i] = 1;
            end else if (owed[i] > 0) begin
                e_stall[i] = 1; e_fie[i] = 1; n_owed[i] = owed[i] - 1;
            end else if (branch_taken) begin
                e_fif[i] = 1; e_fie[i] = 1;
            end else if (dep_on_load()) begin
                e_stall[i] = 1; e_fie[i] = 1; n_owed[i] = bubbles[i] - 1;
            end
        end
    endtask

    task automatic model_commit();
        for (int i = 0; i < 2; i++) begin
            owed[i] = n_owed[i]; waiting[i] = n_waiting[i]; waited[i] = n_waited[i]; err[i] = n_err[i];
            if (e_stall[i] == 1) c_load[i]++;
            if (e_stall[i] == 3) c_mem[i]++;
            if (e_fif[i] != 0) c_flush[i]++;
        end
    endtask

    task automatic check_perf(input int i);
`ifdef HAZARD_PERF_EN
        chk($sformatf("perf_load[%0d]", i), pl_o[i], c_load[i]);
        chk($sformatf("perf_mem[%0d]", i), pm_o[i], c_mem[i]);
        chk($sformatf("perf_flush[%0d]", i), pf_o[i], c_flush[i]);
`else
        chk($sformatf("perf_load[%0d]", i), pl_o[i], 0);
        chk($sformatf("perf_mem[%0d]", i), pm_o[i], 0);
        chk($sformatf("perf_flush[%0d]", i), pf_o[i], 0);
`endif
    endtask

    // first half: inputs already driven at posedge+1, check the Mealy outputs
    task automatic half_a();
        #1;
        model_eval();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("stall[%0d]", i), stall_o[i], e_stall[i]);
            chk($sformatf("flush_if_id[%0d]", i), fif_o[i], e_fif[i]);
            chk($sformatf("flush_id_ex[%0d]", i), fie_o[i], e_fie[i]);
        end
    endtask

    // second half: take the clock edge, check registered state
    task automatic half_b();
        @(posedge clk);
        #1;
        model_commit();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("mem_err[%0d]", i), err_o[i], err[i]);
            check_perf(i);
        end
    endtask

    task automatic cycle();
        half_a();
        half_b();
    endtask

    task automatic set_in(input bit ld, input int rd, input int rs1, input bit u1,
                          input bit br, input bit req, input bit rdy);
        ex_is_load = ld; ex_rd = 5'(rd); id_rs1 = 5'(rs1); id_rs1_used = u1;
        id_rs2 = 5'd0; id_rs2_used = 1'b0;
        branch_taken = br; dmem_req = req; dmem_ready = rdy;
    endtask

    int exp_seq [8] = '{1, 3, 3, 3, 3, 1, 1, 0};

    initial begin
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #1 rst = 1'b1;
        #2;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_stall[%0d]", i), stall_o[i], 0);
            chk($sformatf("rst_flush[%0d]", i), fif_o[i] | fie_o[i], 0);
            chk($sformatf("rst_err[%0d]", i), err_o[i], 0);
            check_perf(i);
        end
        // a live hazard on the inputs must still not show while reset is held
        set_in(1, 5, 5, 1, 1, 0, 0);
        #1;
        chk("rst_hold_stall", stall_o[1], 0);
        chk("rst_hold_flush", fif_o[1] | fie_o[1], 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // load-use, then the two non-hazard cases
        set_in(1, 5, 5, 1, 0, 0, 0); half_a(); chk("lu_a_stall", stall_o[0], 1); half_b();
        set_in(0, 0, 0, 0, 0, 0, 0); half_a(); chk("lu_a_after", stall_o[0], 0); half_b();
        cycle(); cycle();
        set_in(1, 0, 0, 1, 0, 0, 0); half_a(); chk("rd0_nostall", stall_o[1], 0); half_b();
        set_in(1, 5, 5, 0, 0, 0, 0); half_a(); chk("unused_nostall", stall_o[1], 0); half_b();

        // hazard, memory wait on the second bubble for four cycles, then ready
        for (int k = 0; k < 8; k++) begin
            if (k == 0)      set_in(1, 5, 5, 1, 0, 0, 0);
            else if (k < 5)  set_in(0, 0, 0, 0, 0, 1, 0);
            else if (k == 5) set_in(0, 0, 0, 0, 0, 1, 1);
            else             set_in(0, 0, 0, 0, 0, 0, 0);
            half_a();
            chk($sformatf("seq_b_%0d", k), stall_o[1], exp_seq[k]);
            half_b();
        end

        // branch coincident with hazard: flush only, no bubble afterwards
        set_in(1, 7, 7, 1, 1, 0, 0); half_a();
        chk("br_fif", fif_o[1], 1); chk("br_stall", stall_o[1], 0); half_b();
        set_in(0, 0, 0, 0, 0, 0, 0); half_a(); chk("br_after", stall_o[1], 0); half_b();

        // memory timeout: wait well beyond the limit, then complete
        for (int k = 0; k < 7; k++) begin
            set_in(0, 0, 0, 0, 0, 1, 0);
            cycle();
        end
        set_in(0, 0, 0, 0, 0, 1, 1); cycle();
        set_in(0, 0, 0, 0, 0, 0, 0); cycle();
        chk("tmo_sticky", err_o[1], 1);

        // asynchronous reset in the middle of a load stall
        set_in(1, 5, 5, 1, 0, 0, 0); cycle();
        set_in(0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_stall", stall_o[1], 0);
        chk("mid_rst_fie", fie_o[1], 0);
        chk("mid_rst_err", err_o[1], 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cycle();

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            ex_is_load   = 1'($urandom_range(0, 1));
            ex_rd        = 5'($urandom_range(0, 3));
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            id_rs1_used  = 1'($urandom_range(0, 1));
            id_rs2_used  = 1'($urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 3) == 0);
            dmem_req     = 1'($urandom_range(0, 1));
            dmem_ready   = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core; drives the shared `stall` code and the per-stage flush strobes consumed by if_id_reg, id_ex_reg and the PC unit.
- Detects load-use hazards (ID vs EX), data-memory wait and taken-branch redirect.
- Applies a fixed priority between these events and holds multi-cycle stalls with an FSM plus counters.

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (legal 1..7).
- MEM_TIMEOUT, 255, S_MEM cycles without dmem_ready before mem_err sets; 0 disables the check.
- CNT_WIDTH, 32, width of the performance counters.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- id_rs1  in  5  ID source register 1
- id_rs2  in  5  ID source register 2
- id_rs1_used  in  1  ID instruction reads rs1
- id_rs2_used  in  1  ID instruction reads rs2
- ex_rd  in  5  EX destination register
- ex_is_load  in  1  EX instruction is a load
- branch_taken  in  1  EX resolved a taken branch/jump
- dmem_req  in  1  MEM stage has an active data access
- dmem_ready  in  1  data memory completes the access this cycle
- stall  out  STALL_WIDTH  stall code to the pipeline registers
- flush_if_id  out  1  squash the IF/ID instruction
- flush_id_ex  out  1  insert a bubble into ID/EX
- mem_err  out  1  sticky memory timeout flag
- perf_load_stalls  out  CNT_WIDTH  load-stall cycle count
- perf_mem_stalls  out  CNT_WIDTH  memory-stall cycle count
- perf_flushes  out  CNT_WIDTH  taken-branch flush count

Behaviour:
- Async reset: state=S_RUN, load counter=0, ret_state=S_RUN, timeout counter=0, mem_err=0, perf counters=0.
- During reset, outputs stall=STALL_NONE and both flushes=0.
- Outputs are Mealy (combinational from state + inputs) so the pipeline registers see them at the same edge; zero latency.
- hazard = ex_is_load && ex_rd!=0 && ((id_rs1_used && id_rs1==ex_rd) || (id_rs2_used && id_rs2==ex_rd)).
- S_RUN, priority order:
  - (1) dmem_req && !dmem_ready: stall=STALL_MEM, no flush, ret_state=S_RUN, next S_MEM.
  - (2) branch_taken: stall=STALL_NONE, flush_if_id=1, flush_id_ex=1, stay S_RUN; a coincident hazard is discarded.
  - (3) hazard: stall=STALL_LOAD, flush_id_ex=1. If LOAD_STALL_CYCLES>1, load counter=LOAD_STALL_CYCLES-1 and next S_LOAD; otherwise stay S_RUN.
  - (4) else: STALL_NONE, no flush.
- S_LOAD:
  - If dmem_req && !dmem_ready: STALL_MEM, ret_state=S_LOAD, next S_MEM; load counter frozen.
  - Otherwise: STALL_LOAD, flush_id_ex=1, counter decrements; when it is 1 this cycle, next S_RUN. hazard is not re-evaluated.
- S_MEM:
  - While !dmem_ready: STALL_MEM, no flush; branch_taken ignored (EX frozen, held stable upstream).
  - On dmem_ready:
    - ret_state=S_RUN: output STALL_NONE, next S_RUN.
    - ret_state=S_LOAD: output STALL_LOAD with flush_id_ex=1; counter decrements; next S_LOAD, or S_RUN if the counter was 1.
- Timeout counter:
  - Counts in S_MEM and clears on exit.
  - When it reaches MEM_TIMEOUT (if nonzero), mem_err sets and stays set until rst.
  - The FSM keeps waiting after the timeout.
- STALL_BRANCH is reserved and never driven by this block.
- Reset asserted mid-stall returns to S_RUN immediately and asynchronously.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - perf_load_stalls increments each cycle stall==STALL_LOAD.
  - perf_mem_stalls increments each cycle stall==STALL_MEM.
  - perf_flushes increments each cycle flush_if_id=1.
  - All counters saturate at all-ones.
- Undefined: ports remain, driven constant 0, no counter flops.

Decomposition:
- defines.sv holds STALL_WIDTH=2, STALL_NONE=2'd0, STALL_LOAD=2'd1, STALL_BRANCH=2'd2, STALL_MEM=2'd3, plus the FSM state enum (S_RUN, S_LOAD, S_MEM).
- One natural sub-module: hazard_detect, a combinational comparator producing `hazard`. The FSM, counters and perf logic stay in hazard_ctrl.

Test Plan:
- Load-use, LOAD_STALL_CYCLES=1: ex_is_load=1, ex_rd=5, id_rs1=5, id_rs1_used=1 -> exactly one cycle stall=1, flush_id_ex=1, then stall=0.
- ex_rd=0 with a matching rs1, or id_rs1_used=0 -> no stall.
- LOAD_STALL_CYCLES=3, hazard, then dmem_req=1 / dmem_ready=0 for 4 cycles on the second stall cycle -> sequence LOAD, MEM×4, LOAD (the ready cycle), LOAD, NONE.
- branch_taken=1 coincident with hazard -> flush_if_id=1, flush_id_ex=1, stall=0, no later load stall.
- MEM_TIMEOUT=4, dmem_ready held 0 -> mem_err rises after the 4th S_MEM cycle and stays 1 after ready.
- rst pulsed mid-S_LOAD -> stall=0 and flushes=0 immediately, with no clock edge.
- With HAZARD_PERF_EN, after the above sequence -> perf counters match the counted stall/flush cycles. Without it -> all counters 0.
